// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM/BIOS image loader.
package rom_loader_pkg;

  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StFlush
  } state_e;

  // Byte-lane index width; never zero so 8-bit builds still get a legal vector.
  function automatic int unsigned lane_w(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/rom_loader.sv
// Packs the hps_io ioctl byte stream into memory words, one region per image slot.
// Optional ROM_LOADER_CHECKSUM_EN adds a per-image modulo-256 byte checksum.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W               = 21,
  parameter int unsigned DATA_W               = 16,
  parameter int unsigned NUM_IMG              = 2,
  parameter int unsigned REGION_SHIFT         = 17,
  parameter logic [NUM_IMG-1:0] REQ_MASK      = NUM_IMG'(1)
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic [15:0]         ioctl_index,
  output logic                ioctl_wait,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [NUM_IMG-1:0]  loaded,
  output logic                hold_reset,
  output logic                err
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]          csum,
  output logic                csum_valid
`endif
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned LANE_W  = lane_w(BYTES);
  localparam int unsigned LANE_SH = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(BYTES - 1);

  state_e              r_state, w_state_nx;
  logic                r_dl;
  logic [IDX_W-1:0]    r_slot, w_slot_nx;
  logic [ADDR_W-1:0]   r_waddr, w_waddr_nx;
  logic [DATA_W-1:0]   r_din, w_din_nx;
  logic [BYTES-1:0]    r_be, w_be_nx;
  logic                r_skid_vld, w_skid_vld_nx;
  logic [ADDR_W-1:0]   r_skid_waddr, w_skid_waddr_nx;
  logic [LANE_W-1:0]   r_skid_lane, w_skid_lane_nx;
  logic [7:0]          r_skid_data, w_skid_data_nx;
  logic [NUM_IMG-1:0]  r_loaded, w_loaded_nx;
  logic                r_err, w_err_nx;
  logic                r_wait, w_wait_nx;
  logic                w_drop, w_done, w_start, w_acc;

  logic                w_rise, w_idx_ok, w_in_range, w_in_ok, w_in_bad;
  logic [31:0]         w_baddr;
  logic [ADDR_W-1:0]   w_in_waddr;
  logic [LANE_W-1:0]   w_in_lane;
  logic                w_src_vld;
  logic [ADDR_W-1:0]   w_src_waddr;
  logic [LANE_W-1:0]   w_src_lane;
  logic [7:0]          w_src_data;
  logic                w_unused;

  assign w_unused   = ^ioctl_index[15:IDX_W];
  assign w_rise     = ioctl_download & ~r_dl;
  assign w_idx_ok   = 32'(ioctl_index[IDX_W-1:0]) < NUM_IMG;
  assign w_in_range = (ioctl_addr >> REGION_SHIFT) == '0;
  assign w_in_ok    = ioctl_wr & w_in_range;
  assign w_in_bad   = ioctl_wr & ~w_in_range;
  assign w_baddr    = (32'(r_slot) << REGION_SHIFT) + 32'(ioctl_addr);
  assign w_in_waddr = ADDR_W'(w_baddr >> LANE_SH);
  assign w_in_lane  = LANE_W'(w_baddr) & LANE_TOP;

  // A held skid byte is always older than the live ioctl byte, so it goes first.
  assign w_src_vld   = r_skid_vld | w_in_ok;
  assign w_src_waddr = r_skid_vld ? r_skid_waddr : w_in_waddr;
  assign w_src_lane  = r_skid_vld ? r_skid_lane : w_in_lane;
  assign w_src_data  = r_skid_vld ? r_skid_data : ioctl_dout;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_dl         <= 1'b0;
      r_slot       <= '0;
      r_waddr      <= '0;
      r_din        <= '0;
      r_be         <= '0;
      r_skid_vld   <= 1'b0;
      r_skid_waddr <= '0;
      r_skid_lane  <= '0;
      r_skid_data  <= '0;
      r_loaded     <= '0;
      r_err        <= 1'b0;
      r_wait       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_dl         <= ioctl_download;
      r_slot       <= w_slot_nx;
      r_waddr      <= w_waddr_nx;
      r_din        <= w_din_nx;
      r_be         <= w_be_nx;
      r_skid_vld   <= w_skid_vld_nx;
      r_skid_waddr <= w_skid_waddr_nx;
      r_skid_lane  <= w_skid_lane_nx;
      r_skid_data  <= w_skid_data_nx;
      r_loaded     <= w_loaded_nx;
      r_err        <= w_err_nx;
      r_wait       <= w_wait_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_slot_nx       = r_slot;
    w_waddr_nx      = r_waddr;
    w_din_nx        = r_din;
    w_be_nx         = r_be;
    w_skid_vld_nx   = r_skid_vld;
    w_skid_waddr_nx = r_skid_waddr;
    w_skid_lane_nx  = r_skid_lane;
    w_skid_data_nx  = r_skid_data;
    w_loaded_nx     = r_loaded;
    w_err_nx        = r_err;
    w_drop          = 1'b0;
    w_done          = 1'b0;
    w_start         = 1'b0;
    if (r_state != StIdle && w_in_bad) w_err_nx = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (w_rise && w_idx_ok) begin
          w_state_nx    = StCollect;
          w_slot_nx     = ioctl_index[IDX_W-1:0];
          w_loaded_nx   = r_loaded & ~(NUM_IMG'(1) << ioctl_index[IDX_W-1:0]);
          w_be_nx       = '0;
          w_din_nx      = '0;
          w_skid_vld_nx = 1'b0;
          w_start       = 1'b1;
        end
      end
      StCollect: begin
        if (w_src_vld) begin
          if (r_be != '0 && w_src_waddr != r_waddr) begin
            // Issue the current word; the new byte waits in the skid.
            w_state_nx = StWrite;
            if (!r_skid_vld) begin
              w_skid_vld_nx   = 1'b1;
              w_skid_waddr_nx = w_in_waddr;
              w_skid_lane_nx  = w_in_lane;
              w_skid_data_nx  = ioctl_dout;
            end else if (w_in_ok) begin
              w_drop = 1'b1;
            end
          end else begin
            w_waddr_nx                         = w_src_waddr;
            w_din_nx[{w_src_lane, 3'b000} +: 8] = w_src_data;
            w_be_nx[w_src_lane]                = 1'b1;
            if (r_skid_vld) begin
              w_skid_vld_nx   = w_in_ok;
              w_skid_waddr_nx = w_in_waddr;
              w_skid_lane_nx  = w_in_lane;
              w_skid_data_nx  = ioctl_dout;
            end
            if (w_src_lane == LANE_TOP) w_state_nx = StWrite;
          end
        end else if (!ioctl_download) begin
          if (r_be != '0) begin
            w_state_nx = StFlush;
          end else begin
            w_state_nx = StIdle;
            w_done     = 1'b1;
          end
        end
      end
      StWrite, StFlush: begin
        if (w_in_ok) begin
          if (!r_skid_vld) begin
            w_skid_vld_nx   = 1'b1;
            w_skid_waddr_nx = w_in_waddr;
            w_skid_lane_nx  = w_in_lane;
            w_skid_data_nx  = ioctl_dout;
          end else begin
            w_drop = 1'b1;
          end
        end
        if (mem_ack) begin
          w_be_nx  = '0;
          w_din_nx = '0;
          if ((r_state == StWrite && ioctl_download) || w_skid_vld_nx) begin
            w_state_nx = StCollect;
          end else begin
            w_state_nx = StIdle;
            w_done     = 1'b1;
          end
        end
      end
      default: w_state_nx = StIdle;
    endcase
    if (w_done) w_loaded_nx = w_loaded_nx | (NUM_IMG'(1) << r_slot);
    w_wait_nx = (w_state_nx == StWrite) || (w_state_nx == StFlush) || w_skid_vld_nx;
    w_acc     = (r_state != StIdle) && w_in_ok && !w_drop;
  end

  always_comb begin
    mem_req    = (r_state == StWrite) || (r_state == StFlush);
    mem_addr   = r_waddr;
    mem_din    = r_din;
    mem_be     = r_be;
    ioctl_wait = r_wait;
    loaded     = r_loaded;
    err        = r_err;
    hold_reset = ioctl_download || (r_state != StIdle) || ((r_loaded & REQ_MASK) != REQ_MASK);
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_csum_valid;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_csum       <= '0;
      r_csum_valid <= 1'b0;
    end else begin
      if (w_start) begin
        r_csum       <= '0;
        r_csum_valid <= 1'b0;
      end else begin
        if (w_acc) r_csum <= r_csum + ioctl_dout;
        if (w_done) r_csum_valid <= 1'b1;
      end
    end
  end

  assign csum       = r_csum;
  assign csum_valid = r_csum_valid;
`else
  logic w_unused_acc;
  assign w_unused_acc = w_acc ^ w_start;
`endif

endmodule
